// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C/SCCB target.
// States, ACK levels and the default device address.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h21;

endpackage

// File: rtl/i2c_target_if.sv
// Register-side port of the I2C target.
// master: the target; slave: the register file it talks to.
interface i2c_target_if;

    logic [7:0] o_reg_addr;
    logic [7:0] o_wr_data;
    logic       o_wr_stb;
    logic       o_rd_stb;
    logic [7:0] i_rd_data;
    logic       o_busy;

    modport master (
        output o_reg_addr, o_wr_data, o_wr_stb,
        output o_rd_stb, o_busy,
        input  i_rd_data
    );

    modport slave (
        input  o_reg_addr, o_wr_data, o_wr_stb,
        input  o_rd_stb, o_busy,
        output i_rd_data
    );

endinterface

// File: rtl/i2c_line_cond.sv
// Bus line conditioning: 2-FF sync, optional counter filter, edge detect.
// Filter enabled by I2C_TARGET_GLITCH_FILTER_EN.
module i2c_line_cond #(
    parameter int FILTER_LEN = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       prev;

    if (FILTER_LEN < 1) begin : g_bad_len
        $error("FILTER_LEN must be at least 1");
    end

    // Idle bus is high, so reset to 1 to avoid a false edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) sync <= 2'b11;
        else       sync <= {sync[0], i_line};
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] cnt;
    logic          filt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt  <= '0;
            filt <= 1'b1;
        end else if (sync[1] == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt <= sync[1];
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = sync[1];
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) prev <= 1'b1;
        else       prev <= level;
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/i2c_target.sv
// I2C/SCCB target with register pointer, write strobes and auto-increment reads.
// Optional SCL/SDA glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = DEF_DEV_ADDR,
    parameter int         FILTER_LEN = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_scl,
    inout  wire          io_sda,
    i2c_target_if.master regs
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start, stop;

    i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_line(i_scl),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_line(io_sda),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start = sda_fall & scl_lvl;
    assign stop  = sda_rise & scl_lvl;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] byte_in;
    logic       sda_oe, sda_oe_n;
    logic       rw, rw_n;
    logic       ack_ph, ack_ph_n;
    logic       ld, ld_n;
    logic [7:0] reg_addr, reg_addr_n;
    logic [7:0] wr_data, wr_data_n;
    logic       wr_stb, wr_stb_n;
    logic       rd_stb, rd_stb_n;
    logic       busy, busy_n;

    assign io_sda = sda_oe ? 1'b0 : 1'bz;

    assign regs.o_reg_addr = reg_addr;
    assign regs.o_wr_data  = wr_data;
    assign regs.o_wr_stb   = wr_stb;
    assign regs.o_rd_stb   = rd_stb;
    assign regs.o_busy     = busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            sda_oe   <= 1'b0;
            rw       <= 1'b0;
            ack_ph   <= 1'b0;
            ld       <= 1'b0;
            reg_addr <= '0;
            wr_data  <= '0;
            wr_stb   <= 1'b0;
            rd_stb   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            sda_oe   <= sda_oe_n;
            rw       <= rw_n;
            ack_ph   <= ack_ph_n;
            ld       <= ld_n;
            reg_addr <= reg_addr_n;
            wr_data  <= wr_data_n;
            wr_stb   <= wr_stb_n;
            rd_stb   <= rd_stb_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        sda_oe_n   = sda_oe;
        rw_n       = rw;
        ack_ph_n   = ack_ph;
        ld_n       = 1'b0;
        reg_addr_n = reg_addr;
        wr_data_n  = wr_data;
        wr_stb_n   = 1'b0;
        rd_stb_n   = 1'b0;
        busy_n     = busy;
        byte_in    = {shreg[6:0], sda_lvl};

        // Read data arrives the cycle after the request strobe.
        if (ld) begin
            shreg_n  = regs.i_rd_data;
            sda_oe_n = ~regs.i_rd_data[7];
        end

        if (start) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else if (stop) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else begin
            unique case (state)
                IDLE, WAIT_STOP: ;
                ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = byte_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_ph_n = 1'b0;
                            rw_n     = sda_lvl;
                            if (shreg[6:0] == DEV_ADDR) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    // First fall opens the ACK clock, second fall ends it.
                    if (scl_fall) begin
                        if (!ack_ph) begin
                            sda_oe_n = 1'b1;
                            ack_ph_n = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            if (rw) begin
                                rd_stb_n = 1'b1;
                                ld_n     = 1'b1;
                                state_n  = RDATA;
                            end else begin
                                state_n = REG;
                            end
                        end
                    end
                end
                REG, WDATA: begin
                    if (scl_rise) begin
                        shreg_n   = byte_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_ph_n = 1'b0;
                            if (state == REG) begin
                                reg_addr_n = byte_in;
                                state_n    = REG_ACK;
                            end else begin
                                wr_data_n = byte_in;
                                wr_stb_n  = 1'b1;
                                state_n   = WDATA_ACK;
                            end
                        end
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph) begin
                            sda_oe_n = 1'b1;
                            ack_ph_n = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = WDATA;
                            if (state == WDATA_ACK)
                                reg_addr_n = reg_addr + 8'd1;
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_n = 1'b0;
                            ack_ph_n = 1'b0;
                            state_n  = RDATA_ACK;
                        end else begin
                            shreg_n   = {shreg[6:0], 1'b0};
                            sda_oe_n  = ~shreg[6];
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise && !ack_ph) begin
                        if (sda_lvl == ACK) begin
                            reg_addr_n = reg_addr + 8'd1;
                            ack_ph_n   = 1'b1;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end else if (scl_fall && ack_ph) begin
                        rd_stb_n  = 1'b1;
                        ld_n      = 1'b1;
                        bit_cnt_n = '0;
                        state_n   = RDATA;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller plus register model.
// Glitch scenario built only with I2C_TARGET_GLITCH_FILTER_EN.
module tb_i2c_target;

    localparam int Q = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic m_low = 1'b0;
    wire  sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_if rg ();

    i2c_target dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_scl (scl),
        .io_sda(sda),
        .regs  (rg)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign rg.i_rd_data = mem[rg.o_reg_addr];

    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, dut_low = 0;
    logic [7:0] last_addr = 8'h00, last_data = 8'h00;

    always @(negedge clk) begin
        if (rg.o_wr_stb) begin
            wr_cnt++;
            last_addr = rg.o_reg_addr;
            last_data = rg.o_wr_data;
            mem[rg.o_reg_addr] = rg.o_wr_data;
        end
        if (rg.o_rd_stb) rd_cnt++;
        if (rg.o_wr_stb && rg.o_rd_stb) both_cnt++;
        if (sda === 1'b0 && !m_low) dut_low++;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        m_low = 1'b1; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        m_low = 1'b0; tick(Q);
    endtask

    task automatic write_bit(input logic b, input bit glitch);
        m_low = ~b;
        if (glitch) begin
            tick(2); scl = 1'b1; tick(1); scl = 1'b0; tick(Q - 3);
        end else begin
            tick(Q);
        end
        scl = 1'b1; tick(2 * Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        b = sda;      tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i], 1'b0);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(ack, 1'b0);
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++;
        if ({rg.o_reg_addr, rg.o_wr_data} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_regs got=%h exp=0000",
                     {rg.o_reg_addr, rg.o_wr_data});
        end
        n_checks++;
        if ({rg.o_wr_stb, rg.o_rd_stb, rg.o_busy, sda} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ctl got=%b exp=0001",
                     {rg.o_wr_stb, rg.o_rd_stb, rg.o_busy, sda});
        end
        rst = 1'b0;
        tick(Q);
    endtask

    task automatic test_write();
        logic a0, a1, a2, b_mid;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'h42, a0);
        b_mid = rg.o_busy;
        write_byte(8'h12, a1);
        write_byte(8'h80, a2);
        i2c_stop();
        tick(Q);
        n_checks++;
        if ({a0, a1, a2, b_mid} !== 4'b0001) begin
            n_fail++;
            $display("FAIL write_acks_busy got=%b exp=0001", {a0, a1, a2, b_mid});
        end
        n_checks++;
        if (wr_cnt - w0 !== 1) begin
            n_fail++;
            $display("FAIL write_stb_count got=%0d exp=1", wr_cnt - w0);
        end
        n_checks++;
        if ({last_addr, last_data} !== 16'h1280) begin
            n_fail++;
            $display("FAIL write_addr_data got=%h exp=1280", {last_addr, last_data});
        end
        n_checks++;
        if ({rg.o_reg_addr, 7'd0, rg.o_busy} !== 16'h1300) begin
            n_fail++;
            $display("FAIL write_ptr_busy got=%h exp=1300",
                     {rg.o_reg_addr, 7'd0, rg.o_busy});
        end
    endtask

    task automatic test_burst_wrap();
        logic a0, a1, a2, a3;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'h42, a0);
        write_byte(8'hFE, a1);
        write_byte(8'hA1, a2);
        write_byte(8'hA2, a3);
        i2c_stop();
        tick(Q);
        n_checks++;
        if ({a0, a1, a2, a3} !== 4'b0000 || wr_cnt - w0 !== 2) begin
            n_fail++;
            $display("FAIL burst_acks_count got=%b/%0d exp=0000/2",
                     {a0, a1, a2, a3}, wr_cnt - w0);
        end
        n_checks++;
        if ({mem[8'hFE], mem[8'hFF]} !== 16'hA1A2) begin
            n_fail++;
            $display("FAIL burst_mem got=%h exp=a1a2", {mem[8'hFE], mem[8'hFF]});
        end
        n_checks++;
        if (rg.o_reg_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL burst_wrap got=%h exp=00", rg.o_reg_addr);
        end
    endtask

    task automatic test_read();
        logic a0, a1, a2, a3, nack_sda;
        logic [7:0] d0, d1;
        int r0;
        i2c_start();
        write_byte(8'h42, a0);
        write_byte(8'h0A, a1);
        write_byte(8'h76, a2);
        write_byte(8'h73, a3);
        i2c_stop();
        r0 = rd_cnt;
        i2c_start();
        write_byte(8'h42, a0);
        write_byte(8'h0A, a1);
        i2c_start();
        write_byte(8'h43, a2);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        tick(Q);
        nack_sda = sda;
        i2c_stop();
        tick(Q);
        n_checks++;
        if ({a0, a1, a2} !== 3'b000) begin
            n_fail++;
            $display("FAIL read_acks got=%b exp=000", {a0, a1, a2});
        end
        n_checks++;
        if ({d0, d1} !== 16'h7673) begin
            n_fail++;
            $display("FAIL read_data got=%h exp=7673", {d0, d1});
        end
        n_checks++;
        if (rd_cnt - r0 !== 2 || nack_sda !== 1'b1) begin
            n_fail++;
            $display("FAIL read_stb_nack got=%0d/%b exp=2/1", rd_cnt - r0, nack_sda);
        end
        n_checks++;
        if (rg.o_reg_addr !== 8'h0B) begin
            n_fail++;
            $display("FAIL read_ptr got=%h exp=0b", rg.o_reg_addr);
        end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1, b_mid;
        int w0, r0, l0;
        w0 = wr_cnt; r0 = rd_cnt; l0 = dut_low;
        i2c_start();
        write_byte(8'h60, a0);
        b_mid = rg.o_busy;
        write_byte(8'h11, a1);
        i2c_stop();
        tick(Q);
        n_checks++;
        if ({a0, a1, b_mid} !== 3'b110 || dut_low !== l0) begin
            n_fail++;
            $display("FAIL wrong_addr_nack got=%b/%0d exp=110/0",
                     {a0, a1, b_mid}, dut_low - l0);
        end
        n_checks++;
        if (wr_cnt !== w0 || rd_cnt !== r0) begin
            n_fail++;
            $display("FAIL wrong_addr_stb got=%0d/%0d exp=0/0",
                     wr_cnt - w0, rd_cnt - r0);
        end
        i2c_start();
        write_byte(8'h42, a0);
        write_byte(8'h05, a1);
        write_byte(8'h99, a1);
        i2c_stop();
        tick(Q);
        n_checks++;
        if ({a0, last_addr, last_data} !== {1'b0, 16'h0599}) begin
            n_fail++;
            $display("FAIL wrong_addr_recover got=%b/%h exp=0/0599",
                     a0, {last_addr, last_data});
        end
    endtask

    task automatic test_reset_mid();
        logic a0, a1;
        int w0;
        logic [7:0] ptr_before;
        i2c_start();
        write_byte(8'h42, a0);
        write_byte(8'h20, a1);
        ptr_before = rg.o_reg_addr;
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) write_bit(1'b1, 1'b0);
        m_low = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        rst = 1'b1;
        #2;
        n_checks++;
        if ({ptr_before, rg.o_reg_addr, rg.o_busy, sda} !== {16'h2000, 2'b01}) begin
            n_fail++;
            $display("FAIL reset_mid_async got=%h/%h/%b%b exp=20/00/01",
                     ptr_before, rg.o_reg_addr, rg.o_busy, sda);
        end
        tick(2);
        rst = 1'b0;
        scl = 1'b0;
        tick(Q);
        i2c_start();
        write_byte(8'h42, a0);
        write_byte(8'h30, a1);
        write_byte(8'h55, a1);
        i2c_stop();
        tick(Q);
        n_checks++;
        if (wr_cnt - w0 !== 1 || {last_addr, last_data} !== 16'h3055) begin
            n_fail++;
            $display("FAIL reset_mid_recover got=%0d/%h exp=1/3055",
                     wr_cnt - w0, {last_addr, last_data});
        end
        n_checks++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("FAIL strobe_overlap got=%0d exp=0", both_cnt);
        end
    endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic a0, a1, a2;
        int w0;
        logic [7:0] d;
        d = 8'h5A;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'h42, a0);
        write_byte(8'h40, a1);
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == 4);
        read_bit(a2);
        i2c_stop();
        tick(Q);
        n_checks++;
        if ({a0, a1, a2} !== 3'b000 || wr_cnt - w0 !== 1
            || {last_addr, last_data} !== 16'h405A) begin
            n_fail++;
            $display("FAIL glitch_byte got=%b/%0d/%h exp=000/1/405a",
                     {a0, a1, a2}, wr_cnt - w0, {last_addr, last_data});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_burst_wrap();
        test_read();
        test_wrong_addr();
        test_reset_mid();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
I2C/SCCB responder: the target-side counterpart of the team's i2c_master, used as a camera-register model in benches and as a config port on FPGA.
- Oversamples SCL/SDA on i_clk; detects START, repeated START and STOP.
- Matches a 7-bit device address, ACKs, and takes a register pointer byte.
- Writes: emits a write strobe per data byte. Reads: fetches and shifts out register data, auto-incrementing the pointer.

Parameters:
DEV_ADDR, 7'h21, 7-bit target address (OV7670 default).
FILTER_LEN, 3, consecutive equal samples needed to accept a new SCL/SDA level (only with the optional filter).

Ports:
i_clk  input  1  system clock; at least 8x SCL frequency.
i_rst  input  1  asynchronous, active-high reset.
i_scl  input  1  bus SCL.
io_sda  inout  1  bus SDA; driven only 0 or Z.
o_reg_addr  output  8  current register pointer.
o_wr_data  output  8  received data byte; valid with o_wr_stb.
o_wr_stb  output  1  one-cycle pulse: write o_wr_data to o_reg_addr.
o_rd_stb  output  1  one-cycle pulse: requests the register at o_reg_addr.
i_rd_data  input  8  read data; sampled exactly 1 i_clk after o_rd_stb.
o_busy  output  1  high from an address-matched START until STOP or a non-matching address.

Behaviour:
- Reset values: o_reg_addr=0, o_wr_data=0, o_wr_stb=0, o_rd_stb=0, o_busy=0, SDA released (Z), state IDLE. Synchronizers reset to 1.
- Input conditioning: 2-FF synchronizer on SCL and SDA, then a previous-sample register for edge detection.
  - START = SDA falls while SCL high. STOP = SDA rises while SCL high.
  - Bits are sampled on the SCL rising edge. SDA drive changes only on the SCL falling edge, in the cycle after it is detected.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- START from any state: go to ADDR, clear the bit counter (count 0..7), release SDA. This handles repeated START.
- STOP from any state: go to IDLE, release SDA, clear o_busy. The STOP is not ACKed.
- ADDR: shift in 8 bits MSB first. After the 8th bit:
  - addr[7:1]==DEV_ADDR: go to ADDR_ACK, set o_busy, drive SDA low for the ACK clock.
  - Otherwise: go to WAIT_STOP, SDA stays Z (NACK).
- ADDR_ACK: on the SCL falling edge that ends the ACK clock, release SDA.
  - If R/W=0: go to REG.
  - If R/W=1: pulse o_rd_stb, capture i_rd_data one cycle later, drive bit7 (0 = low, 1 = Z), go to RDATA.
- REG: after 8 bits, load o_reg_addr and ACK (REG_ACK), then go to WDATA.
- WDATA: after 8 bits, set o_wr_data, pulse o_wr_stb (one cycle, at the 8th SCL rise), ACK, go to WDATA_ACK. After the ACK, increment o_reg_addr (8-bit wrap, 8'hFF -> 8'h00) and return to WDATA.
- Read pointer semantics: write address+pointer, repeated START, read address; data starts at the written pointer.
- RDATA: shift out MSB first, advancing on each SCL falling edge. After 8 bits, release SDA and go to RDATA_ACK.
- RDATA_ACK: sample the controller's ACK on SCL rise.
  - ACK (0): increment o_reg_addr, then on SCL fall pulse o_rd_stb, load, drive next bit7, go to RDATA.
  - NACK (1): go to WAIT_STOP with SDA released.
- WAIT_STOP: ignore bus until START or STOP.
- Simultaneous events: START/STOP detection has priority over bit sampling in the same cycle. o_wr_stb and o_rd_stb are never both high.
- Reset mid-transfer: SDA is released immediately (asynchronous) and state returns to IDLE. The bus is recovered by the controller's next START.

Optional Feature:
I2C_TARGET_GLITCH_FILTER_EN
- Defined: after the synchronizers, SCL and SDA each pass a counter filter. The filtered level changes only after FILTER_LEN consecutive equal samples. Minimum i_clk/SCL ratio rises to 4*(FILTER_LEN+2).
- Undefined: filters absent; synchronizer output is used directly. FILTER_LEN is unused.

Decomposition:
- Package i2c_pkg: state enum type, ACK/NACK constants, default DEV_ADDR constant.
- One sub-module, i2c_line_cond: synchronizer plus optional filter plus edge detect.
  - Instantiated twice (SCL, SDA).
  - Outputs level, rise and fall.

Test Plan:
1. Write: START, 0x42, 0x12, 0x80, STOP -> three ACKs; o_wr_stb once with o_reg_addr=0x12, o_wr_data=0x80; o_reg_addr=0x13 after; o_busy low after STOP.
2. Burst write at 0xFE: 0xFE, then data 0xA1, 0xA2 -> writes to 0xFE then 0xFF; pointer wraps to 0x00.
3. Read: write pointer 0x0A, repeated START, 0x43, model returns 0x76/0x73 -> bytes 0x76, 0x73 read; master ACK then NACK; two o_rd_stb pulses; SDA Z after NACK.
4. Wrong address 0x60 -> SDA never driven low, no strobes, o_busy stays 0; next START with 0x42 is ACKed normally.
5. Assert i_rst during the 4th data bit of a write -> SDA Z within one cycle, all outputs reset, no o_wr_stb; a following full write succeeds.
6. With I2C_TARGET_GLITCH_FILTER_EN: inject a 1-cycle SCL high glitch during a data bit -> no extra bit shifted, byte 0x5A received intact.
